// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per cycle, with divide-by-zero and overflow detection.
module seq_divider #(
   parameter int N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [N-1:0]  dreg;
   logic [N-1:0]  sreg;
   logic [N:0]    preg;
   logic [CW-1:0] cnt;

   logic          accept;
   logic          zero;
   logic          err;
   logic [N:0]    shifted;
   logic [N+1:0]  diff;
   logic          ge;

   always_comb begin
      accept   = start && (state == IDLE || state == DONE);
      zero     = (divisor == '0);
      err      = zero || (dividend[2*N-1:N] >= divisor);
      shifted  = {preg[N-1:0], sreg[N-1]};
      // Borrow out of the top bit means the trial subtraction went negative
      diff     = {1'b0, shifted} + {2'b11, ~dreg} + (N+2)'(1);
      ge       = ~diff[N+1];
      busy     = (state == RUN);
      done     = (state == DONE);
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = err ? DONE : RUN;
         RUN:  if (cnt == LAST) state_nx = DONE;
         DONE: begin
            if (accept) state_nx = err ? DONE : RUN;
            else        state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dreg        <= '0;
         sreg        <= '0;
         preg        <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            dreg        <= divisor;
            preg        <= {1'b0, dividend[2*N-1:N]};
            sreg        <= dividend[N-1:0];
            cnt         <= '0;
            div_by_zero <= zero;
            overflow    <= !zero && err;
            if (err) begin
               quotient  <= '1;
               remainder <= dividend[N-1:0];
            end
         end else if (state == RUN) begin
            // Shift register doubles as the quotient accumulator
            preg <= ge ? diff[N:0] : shifted;
            sreg <= {sreg[N-2:0], ge};
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
               quotient  <= {sreg[N-2:0], ge};
               remainder <= ge ? diff[N-1:0] : shifted[N-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases plus a random run
// against an arithmetic reference model.
module tb_seq_divider;

   localparam int N = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           div_by_zero;
   logic           overflow;

   int vectors = 0;
   int errs = 0;

   seq_divider #(.N(N)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .dividend(dividend),
      .divisor(divisor),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic model(input logic [31:0] dd, input logic [15:0] dv,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output logic ov);
      if (dv == 16'd0) begin
         dz = 1'b1; ov = 1'b0; q = '1; r = dd[15:0];
      end else if (dd[31:16] >= dv) begin
         dz = 1'b0; ov = 1'b1; q = '1; r = dd[15:0];
      end else begin
         dz = 1'b0; ov = 1'b0;
         q = 16'(dd / {16'd0, dv});
         r = 16'(dd % {16'd0, dv});
      end
   endtask

   // Edges are counted with the accepting edge as edge 1.
   task automatic run_div(input logic [31:0] dd, input logic [15:0] dv,
                          output int edges, output int bcyc, output bit to);
      start = 1'b1; dividend = dd; divisor = dv;
      @(posedge clk); #1;
      start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
      edges = 1; bcyc = 0;
      while (!done && edges < 40) begin
         if (busy) bcyc++;
         @(posedge clk); #1;
         edges++;
      end
      to = !done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; dividend = 32'h64; divisor = 16'd7;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         errs++; $display("FAIL reset_ctrl busy/done=%b required 00", {busy, done});
      end
      vectors++;
      if ({quotient, remainder} !== 32'd0) begin
         errs++; $display("FAIL reset_data q/r=%h required 0", {quotient, remainder});
      end
      vectors++;
      if ({div_by_zero, overflow} !== 2'b00) begin
         errs++; $display("FAIL reset_flags=%b required 00", {div_by_zero, overflow});
      end
      start = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({busy, done} !== 2'b00) begin
         errs++; $display("FAIL reset_prio busy/done=%b required 00", {busy, done});
      end
   endtask

   task automatic test_basic();
      int e, b; bit to;
      run_div(32'h0000_0064, 16'd7, e, b, to);
      vectors++;
      if (to || e != 17 || b != 16) begin
         errs++; $display("FAIL basic_timing edges=%0d busy=%0d required 17/16", e, b);
      end
      vectors++;
      if ({quotient, remainder, div_by_zero, overflow} !== {16'd14, 16'd2, 2'b00}) begin
         errs++; $display("FAIL basic_result q=%0d r=%0d required 14/2", quotient, remainder);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || quotient !== 16'd14 || remainder !== 16'd2) begin
         errs++; $display("FAIL basic_hold done=%b q=%0d r=%0d required 0/14/2", done, quotient, remainder);
      end
   endtask

   task automatic test_max();
      int e, b; bit to;
      run_div(32'hFFFE_0001, 16'hFFFF, e, b, to);
      vectors++;
      if (to || {quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'h0, 2'b00}) begin
         errs++; $display("FAIL max_result q=%h r=%h f=%b required ffff/0/00", quotient, remainder, {div_by_zero, overflow});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_div_zero();
      int e, b; bit to;
      run_div(32'h1234_5678, 16'd0, e, b, to);
      vectors++;
      if (to || e != 1) begin
         errs++; $display("FAIL dz_timing edges=%0d required 1", e);
      end
      vectors++;
      if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'h5678, 2'b10}) begin
         errs++; $display("FAIL dz_result q=%h r=%h f=%b required ffff/5678/10", quotient, remainder, {div_by_zero, overflow});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      int e, b; bit to;
      run_div(32'h0007_0000, 16'd7, e, b, to);
      vectors++;
      if (to || e != 1) begin
         errs++; $display("FAIL ov_timing edges=%0d required 1", e);
      end
      vectors++;
      if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'h0, 2'b01}) begin
         errs++; $display("FAIL ov_result q=%h r=%h f=%b required ffff/0/01", quotient, remainder, {div_by_zero, overflow});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start();
      int e = 1;
      start = 1'b1; dividend = 32'h64; divisor = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; e++; end
      start = 1'b1; dividend = 32'h0000_0100; divisor = 16'd3;
      @(posedge clk); #1; e++;
      start = 1'b0;
      while (!done && e < 40) begin @(posedge clk); #1; e++; end
      vectors++;
      if (!done || e != 17 || quotient !== 16'd14 || remainder !== 16'd2) begin
         errs++; $display("FAIL ignore_start edges=%0d q=%0d r=%0d required 17/14/2", e, quotient, remainder);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_rst_mid_run();
      bit seen = 0;
      start = 1'b1; dividend = 32'h64; divisor = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 36'd0) begin
         errs++; $display("FAIL rst_mid_run busy=%b done=%b q=%h r=%h required all 0", busy, done, quotient, remainder);
      end
      repeat (20) begin @(posedge clk); #1; if (done) seen = 1; end
      vectors++;
      if (seen) begin
         errs++; $display("FAIL rst_no_done done_seen=1 required 0");
      end
   endtask

   task automatic test_back_to_back();
      int e, b; bit to;
      run_div(32'h0007_0000, 16'd7, e, b, to);
      start = 1'b1; dividend = 32'd100; divisor = 16'd10;
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
         errs++; $display("FAIL b2b_accept busy=%b ov=%b dz=%b required 1/0/0", busy, overflow, div_by_zero);
      end
      e = 1;
      while (!done && e < 40) begin @(posedge clk); #1; e++; end
      vectors++;
      if (!done || e != 17 || quotient !== 16'd10 || remainder !== 16'd0) begin
         errs++; $display("FAIL b2b_result edges=%0d q=%0d r=%0d required 17/10/0", e, quotient, remainder);
      end
   endtask

   task automatic test_random();
      int e, b, k, xe; bit to;
      logic [31:0] dd; logic [15:0] dv, eq, er; logic ez, eo;
      for (int i = 0; i < 10000; i++) begin
         k = $urandom_range(0, 9);
         dd[15:0] = 16'($urandom);
         if (k == 0) begin
            dv = 16'd0; dd[31:16] = 16'($urandom);
         end else if (k < 8) begin
            dv = 16'($urandom_range(1, 65535));
            dd[31:16] = 16'($urandom_range(dv, 65535));
         end else begin
            dv = 16'($urandom_range(1, 65535));
            dd[31:16] = 16'($urandom_range(0, dv - 1));
         end
         model(dd, dv, eq, er, ez, eo);
         xe = (ez || eo) ? 1 : 17;
         run_div(dd, dv, e, b, to);
         vectors++;
         if (to || e != xe || {quotient, remainder, div_by_zero, overflow} !== {eq, er, ez, eo}) begin
            errs++;
            $display("FAIL rand dd=%h dv=%h edges=%0d q=%h r=%h f=%b required %0d/%h/%h/%b",
                     dd, dv, e, quotient, remainder, {div_by_zero, overflow}, xe, eq, er, {ez, eo});
         end
         if (!ez && !eo) begin
            vectors++;
            if ({16'd0, quotient} * {16'd0, dv} + {16'd0, remainder} !== dd || remainder >= dv) begin
               errs++; $display("FAIL rand_identity dd=%h dv=%h q=%h r=%h", dd, dv, quotient, remainder);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      test_reset();
      test_basic();
      test_max();
      test_div_zero();
      test_overflow();
      test_ignore_start();
      test_rst_mid_run();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
